// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// One iteration per clock; result is {remainder, quotient} for the HI/LO path.
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] work;
  logic [DATA_W-1:0]   divisor_mag;
  logic                neg_dividend;
  logic                neg_divisor;

  logic                dividend_sign;
  logic                divisor_sign;
  logic [DATA_W-1:0]   dividend_mag;
  logic [DATA_W-1:0]   divisor_mag_in;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] work_next;
  logic [DATA_W-1:0]   quot_fin;
  logic [DATA_W-1:0]   rem_fin;
  logic                last_iter;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  // NOTE: every signal written here gets a value on every path (no else-less ifs), so no latches are inferred.
  always_comb begin
    dividend_sign  = signed_div_i & opdata1_i[DATA_W-1];
    divisor_sign   = signed_div_i & opdata2_i[DATA_W-1];
    dividend_mag   = dividend_sign ? negate(opdata1_i) : opdata1_i;
    divisor_mag_in = divisor_sign  ? negate(opdata2_i) : opdata2_i;

    // Trial subtraction of the divisor from the top 33 bits of the shifted remainder.
    diff      = work[2*DATA_W-1:DATA_W-1] - {1'b0, divisor_mag};
    work_next = diff[DATA_W] ? {work[2*DATA_W-2:0], 1'b0}
                             : {diff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};

    quot_fin  = (neg_dividend ^ neg_divisor) ? negate(work_next[DATA_W-1:0])
                                             : work_next[DATA_W-1:0];
    rem_fin   = neg_dividend ? negate(work_next[2*DATA_W-1:DATA_W])
                             : work_next[2*DATA_W-1:DATA_W];
    last_iter = (cnt == CNT_W'(DATA_W - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_FREE;
      cnt          <= '0;
      work         <= '0;
      divisor_mag  <= '0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      result_o     <= '0;
      ready_o      <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state        <= S_ON;
              neg_dividend <= dividend_sign;
              neg_divisor  <= divisor_sign;
              divisor_mag  <= divisor_mag_in;
              work         <= {{DATA_W{1'b0}}, dividend_mag};
              cnt          <= '0;
            end
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            state    <= S_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          // A flush wins over the iteration in progress.
          if (annul_i) begin
            state <= S_FREE;
            cnt   <= '0;
          end else begin
            work <= work_next;
            cnt  <= cnt + CNT_W'(1);
            if (last_iter) begin
              state    <= S_END;
              result_o <= {rem_fin, quot_fin};
              ready_o  <= 1'b1;
            end
          end
        end
        default: begin
          // END: hold the result until EX drops its request.
          if (annul_i || !start_i) begin
            state   <= S_FREE;
            ready_o <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy_o = (state != S_FREE);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected {rem, quot} values
// checked against a behavioural 64-bit division model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Reference: widen to 64 bits so the signed overflow case cannot trap.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a falling edge; the next rising edge is the accepting edge E0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    exp_q.push_back(model(a, b, sgn));
  endtask

  // Returns edges after E0 until ready_o is seen (-1 on timeout); operands are
  // scrambled after E0 and busy/ready consistency is tracked while waiting.
  task automatic wait_ready(input int limit, output int lat, output bit consistent);
    int n = 0;
    consistent = 1'b1;
    lat = -1;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (!busy_o) consistent = 1'b0;
      if (ready_o) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    total++; if (result_o !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat; bit cons; logic [63:0] exp;
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    wait_ready(40, lat, cons);
    exp = exp_q.pop_front();
    total++; if (lat !== 32) begin bad++; $display("FAIL divu_latency got=%0d want=32", lat); end
    total++; if (!cons) begin bad++; $display("FAIL divu_busy got=0 want=1"); end
    total++; if (result_o !== exp) begin bad++; $display("FAIL divu_result got=%h want=%h", result_o, exp); end
    total++; if (result_o !== 64'h00000002_0000000E) begin bad++; $display("FAIL divu_literal got=%h want=000000020000000e", result_o); end
    @(negedge clk);
    total++; if (!(ready_o === 1'b1 && result_o === exp)) begin bad++; $display("FAIL end_hold ready=%b got=%h want=%h", ready_o, result_o, exp); end
    start_i = 1'b0;
    @(negedge clk);
    total++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin bad++; $display("FAIL end_release busy=%b ready=%b want=0,0", busy_o, ready_o); end
  endtask

  task automatic test_signed();
    logic [31:0] ta [4] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] tb [4] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
    logic [63:0] tr [4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                            64'h00000000_80000000, 64'h00000000_FFFFFFFF};
    int lat; bit cons; logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(ta[i], tb[i], 1'b1);
      wait_ready(40, lat, cons);
      exp = exp_q.pop_front();
      total++; if (lat !== 32) begin bad++; $display("FAIL signed_latency[%0d] got=%0d want=32", i, lat); end
      total++; if (result_o !== exp) begin bad++; $display("FAIL signed_model[%0d] got=%h want=%h", i, result_o, exp); end
      total++; if (result_o !== tr[i]) begin bad++; $display("FAIL signed_literal[%0d] got=%h want=%h", i, result_o, tr[i]); end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero();
    int lat; bit cons; logic [63:0] exp;
    @(negedge clk);
    issue(32'd5, 32'd0, 1'b0);
    wait_ready(40, lat, cons);
    exp = exp_q.pop_front();
    total++; if (lat !== 1) begin bad++; $display("FAIL byzero_latency got=%0d want=1", lat); end
    total++; if (result_o !== exp) begin bad++; $display("FAIL byzero_result got=%h want=%h", result_o, exp); end
    start_i = 1'b0;
    @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL byzero_release got=%b want=0", busy_o); end
  endtask

  task automatic test_annul();
    bit saw_ready = 1'b0;
    @(negedge clk);
    issue(32'd1000, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    void'(exp_q.pop_back());
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL annul_busy got=%b want=0", busy_o); end
    repeat (40) begin
      @(negedge clk);
      if (ready_o || busy_o) saw_ready = 1'b1;
    end
    total++; if (saw_ready) begin bad++; $display("FAIL annul_ready got=1 want=0"); end
  endtask

  task automatic test_start_annul_free();
    bit moved = 1'b0;
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd5;
    repeat (3) begin
      @(negedge clk);
      if (busy_o) moved = 1'b1;
    end
    total++; if (moved) begin bad++; $display("FAIL start_annul_free busy=1 want=0"); end
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; bit cons; logic [63:0] exp;
    @(negedge clk);
    issue(32'd12345, 32'd67, 1'b0);
    repeat (21) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (result_o !== 64'd0 || ready_o !== 1'b0 || busy_o !== 1'b0)
      begin bad++; $display("FAIL reset_mid result=%h ready=%b busy=%b want=0,0,0", result_o, ready_o, busy_o); end
    exp_q.delete();
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_ready(40, lat, cons);
    exp = exp_q.pop_front();
    total++; if (lat !== 32) begin bad++; $display("FAIL post_reset_latency got=%0d want=32", lat); end
    total++; if (result_o !== 64'h00000000_FFFFFFFF) begin bad++; $display("FAIL post_reset_result got=%h want=00000000ffffffff", result_o); end
    total++; if (result_o !== exp) begin bad++; $display("FAIL post_reset_model got=%h want=%h", result_o, exp); end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; bit cons; logic [63:0] exp;
    logic [31:0] a, b; logic sgn;
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = b & 32'h0000000F;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: a = a & 32'h000000FF;
        default: ;
      endcase
      if (b == 32'd0) b = 32'd1;
      sgn = 1'($urandom_range(0, 1));
      @(negedge clk);
      issue(a, b, sgn);
      wait_ready(40, lat, cons);
      exp = exp_q.pop_front();
      total++; if (lat !== 32 || !cons) begin bad++; $display("FAIL rand_timing[%0d] lat=%0d consistent=%0b want=32,1", i, lat, cons); end
      total++; if (result_o !== exp) begin bad++; $display("FAIL rand_result[%0d] a=%h b=%h s=%b got=%h want=%h", i, a, b, sgn, result_o, exp); end
      start_i = 1'b0;
      @(negedge clk);
      total++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin bad++; $display("FAIL rand_release[%0d] busy=%b ready=%b want=0,0", i, busy_o, ready_o); end
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_start_annul_free();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
